seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle signed 32-bit integer divider for the processor's execute stage.
//  Consumes the zero-detect result on the divisor to raise a divide-by-zero exception early.
//  Runs one restoring-division step per clock.
//  Delivers a one-cycle ready pulse to the stall/writeback logic.
// PARAMETERS
//  WIDTH  32  operand/quotient width in bits; the iteration count equals WIDTH
// PORTS
//  clock            in   1      single system clock, rising edge
//  reset_n          in   1      asynchronous, active-low reset
//  ctrl_div         in   1      start pulse; operands are sampled in this cycle
//  data_operandA    in   WIDTH  dividend, two's complement
//  data_operandB    in   WIDTH  divisor, two's complement
//  divisor_is_zero  in   1      zero-detect output on data_operandB, valid with ctrl_div
//  data_result      out  WIDTH  quotient, truncated toward zero
//  data_exception   out  1      divide-by-zero (or trapped overflow) flag, qualified by data_resultRDY
//  data_resultRDY   out  1      one-cycle pulse: result and exception are valid
//  busy             out  1      high while an operation is in flight
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE; all outputs and internal registers are 0.
//  - States: IDLE, RUN, DONE.
//  - ctrl_div=1 in any state: operands are latched and the current operation is aborted.
//    - divisor_is_zero=1 -> go to DONE; result=0, exception=1.
//    - Otherwise -> RUN with iteration counter=0.
//  - RUN: divide |A| by |B| unsigned, one restoring step per cycle.
//    - Remainder register is WIDTH+1 bits.
//    - Counter runs 0..WIDTH-1; on count WIDTH-1 go to DONE.
//  - DONE: assert data_resultRDY for exactly 1 cycle, then go to IDLE.
//    - Quotient is negated if sign(A) XOR sign(B); exception=0.
//  - Latency, start taken at edge N:
//    - Normal operation: data_resultRDY high in cycle N+WIDTH+1 (33 for WIDTH=32).
//    - Divide by zero: data_resultRDY high in cycle N+1.
//  - data_result and data_exception hold their values after the ready pulse until the next ready pulse.
//  - busy=1 in RUN and DONE; busy=0 in IDLE.
//  - A ctrl_div in the same cycle as DONE takes priority: no ready pulse for the old operation.
//  - INT_MIN / -1 without the macro: result 0x80000000, exception=0 (wraps).
//  - Dividend 0: result 0, exception=0, normal latency.
//  - Reset asserted mid-RUN: the operation is discarded; no ready pulse.
//  - The unsigned magnitude of INT_MIN (0x80000000) must be handled correctly.
// CONFIGURATION
//  DIV_OVF_TRAP_EN defined:
//  - INT_MIN / -1 is detected at start.
//  - Behaves as divide by zero: DONE next cycle, result=0, exception=1.
//  DIV_OVF_TRAP_EN undefined:
//  - No overflow check; the wrap behaviour above applies.
// TESTING
//  - 100 / 7 -> result 14 (0x0000000E), exception 0, RDY exactly 33 cycles after start, busy high in between.
//  - -100 / 7 -> -14 (0xFFFFFFF2).
//  - 100 / -7 -> -14.
//  - -100 / -7 -> 14; all with exception 0.
//  - 5 / 0 with divisor_is_zero=1 -> RDY next cycle, result 0, exception 1, busy low afterwards.
//  - 0x80000000 / 0xFFFFFFFF:
//    - Without DIV_OVF_TRAP_EN -> result 0x80000000, exception 0, 33 cycles.
//    - With DIV_OVF_TRAP_EN -> RDY next cycle, result 0, exception 1.
//  - Start 1000/3, then re-pulse ctrl_div with 50/5 at cycle 10.
//    - Exactly one RDY pulse, 33 cycles after the second start, result 10.
//  - Start 1000/3, drop reset_n at cycle 15.
//    - All outputs are 0 immediately; no RDY pulse.
//    - After release, 9/3 -> result 3.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed integer divider, one restoring step per clock.
// Quotient truncates toward zero; a divide-by-zero raises data_exception.
// Optional build macro DIV_OVF_TRAP_EN: when defined, INT_MIN / -1 is caught at
// start and reported like a divide by zero instead of wrapping to INT_MIN.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             divisor_is_zero,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH:0]   rem_reg;     // partial remainder, one bit wider than the operands
    logic [WIDTH-1:0] quo_reg;     // holds |A| at start, shifts into the quotient
    logic [WIDTH-1:0] dvsr_reg;    // |B|
    logic             neg_reg;     // quotient must be negated at the end
    logic             exc_reg;     // operation ends in an exception

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             start_exc;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] quo_final;

    // Operand magnitudes, exception detection and the restoring-step datapath.
    // Negating INT_MIN yields 0x80..0, which read as unsigned is its exact magnitude.
    always_comb begin
        mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
`ifdef DIV_OVF_TRAP_EN
        start_exc = divisor_is_zero |
                    ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (data_operandB == {WIDTH{1'b1}}));
`else
        start_exc = divisor_is_zero;
`endif
        // Shift the next dividend bit into the remainder and try subtracting |B|;
        // a set top bit of the trial means the subtraction must be undone.
        rem_shift = {rem_reg, quo_reg[WIDTH-1]};
        trial     = rem_shift - {2'b00, dvsr_reg};
        quo_final = neg_reg ? -quo_reg : quo_reg;
    end

    // Control FSM and datapath registers; a start request overrides every state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            dvsr_reg       <= '0;
            neg_reg        <= 1'b0;
            exc_reg        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_div) begin
                rem_reg   <= '0;
                quo_reg   <= mag_a;
                dvsr_reg  <= mag_b;
                neg_reg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                exc_reg   <= start_exc;
                count_reg <= '0;
                busy      <= 1'b1;
                state_reg <= start_exc ? DONE : RUN;
            end else begin
                case (state_reg)
                    RUN: begin
                        if (trial[WIDTH+1]) begin
                            rem_reg <= rem_shift[WIDTH:0];
                        end else begin
                            rem_reg <= trial[WIDTH:0];
                        end
                        quo_reg   <= {quo_reg[WIDTH-2:0], ~trial[WIDTH+1]};
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == LAST_STEP) begin
                            state_reg <= DONE;
                        end
                    end
                    DONE: begin
                        data_resultRDY <= 1'b1;
                        data_result    <= exc_reg ? '0 : quo_final;
                        data_exception <= exc_reg;
                        busy           <= 1'b0;
                        state_reg      <= IDLE;
                    end
                    default: begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed operations with a result scoreboard.
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        divisor_is_zero;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ctrl_div        (ctrl_div),
        .data_operandA   (data_operandA),
        .data_operandB   (data_operandB),
        .divisor_is_zero (divisor_is_zero),
        .data_result     (data_result),
        .data_exception  (data_exception),
        .data_resultRDY  (data_resultRDY),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; drives a one-cycle start and returns in the
    // cycle right after the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push,
                            input logic [31:0] er, input logic ee, input int el);
        exp_t e;
        if (push) begin
            e.res = er;
            e.exc = ee;
            e.lat = el;
            sb.push_back(e);
        end
        data_operandA   = a;
        data_operandB   = b;
        divisor_is_zero = (b == 32'd0);
        ctrl_div        = 1'b1;
        @(negedge clock);
        ctrl_div        = 1'b0;
        $display("start %s: A=%h B=%h", push ? "tracked" : "untracked", a, b);
    endtask

    // Waits (bounded) for the ready pulse and checks it against the scoreboard head.
    task automatic wait_rdy(input string tag);
        exp_t e;
        int   j;
        bit   seen;
        bit   busy_ok;
        e       = sb.pop_front();
        j       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && j <= 80) begin
            if (data_resultRDY === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(negedge clock);
                j++;
            end
        end
        $display("op %s: rdy=%0d latency=%0d result=%h exc=%0d", tag, seen, j, data_result, data_exception);
        check({tag, " rdy_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(j), 32'(e.lat));
        check({tag, " result"}, data_result, e.res);
        check({tag, " exception"}, 32'(data_exception), 32'(e.exc));
        check({tag, " busy_in_flight"}, 32'(busy_ok), 32'd1);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        @(negedge clock);
        check({tag, " rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
        check({tag, " result_held"}, data_result, e.res);
    endtask

    task automatic no_rdy(input int n, input string tag);
        bit saw;
        saw = 1'b0;
        repeat (n) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) saw = 1'b1;
        end
        check(tag, 32'(saw), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          sa;
        int          sbv;

        reset_n         = 1'b0;
        ctrl_div        = 1'b0;
        data_operandA   = '0;
        data_operandB   = '0;
        divisor_is_zero = 1'b0;
        repeat (3) @(negedge clock);
        check("reset result", data_result, 32'd0);
        check("reset exception", 32'(data_exception), 32'd0);
        check("reset rdy", 32'(data_resultRDY), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        start_op(32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 33);
        wait_rdy("100/7");
        start_op(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0, 33);
        wait_rdy("-100/7");
        start_op(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 1'b0, 33);
        wait_rdy("100/-7");
        start_op(-32'sd100, -32'sd7, 1'b1, 32'd14, 1'b0, 33);
        wait_rdy("-100/-7");
        start_op(32'd5, 32'd0, 1'b1, 32'd0, 1'b1, 1);
        wait_rdy("5/0");
`ifdef DIV_OVF_TRAP_EN
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1);
`else
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 33);
`endif
        wait_rdy("intmin/-1");
        start_op(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b0, 33);
        wait_rdy("intmin/1");
        start_op(32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 1'b0, 33);
        wait_rdy("intmin/2");
        start_op(32'd0, 32'd5, 1'b1, 32'd0, 1'b0, 33);
        wait_rdy("0/5");
        start_op(32'd7, 32'd100, 1'b1, 32'd0, 1'b0, 33);
        wait_rdy("7/100");

        // New start while the divide-by-zero sits in DONE: its pulse is dropped.
        start_op(32'd5, 32'd0, 1'b0, 32'd0, 1'b0, 0);
        start_op(32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 33);
        wait_rdy("start_over_done");

        // Restart mid-run: only the second operation reports.
        start_op(32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, 0);
        no_rdy(9, "abort no early rdy");
        start_op(32'd50, 32'd5, 1'b1, 32'd10, 1'b0, 33);
        wait_rdy("restart 50/5");

        // Reset in the middle of a run.
        start_op(32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, 0);
        no_rdy(14, "pre-reset no rdy");
        check("pre-reset busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrun reset result", data_result, 32'd0);
        check("midrun reset exception", 32'(data_exception), 32'd0);
        check("midrun reset rdy", 32'(data_resultRDY), 32'd0);
        check("midrun reset busy", 32'(busy), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        no_rdy(40, "post-reset no rdy");
        start_op(32'd9, 32'd3, 1'b1, 32'd3, 1'b0, 33);
        wait_rdy("9/3 after reset");

        // A few random operands against the language's own signed division.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (rb == 32'd0) rb = 32'd1;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            sa  = ra;
            sbv = rb;
            start_op(ra, rb, 1'b1, 32'(sa / sbv), 1'b0, 33);
            wait_rdy("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
